// File: rtl/add_serial_pkg.sv
// Shared types and default sizing for the serial-adder operand sequencer.
package add_serial_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_ADD_LAT    = 10;
  localparam int DEF_EN_CYCLES  = 2;
  localparam int DEF_FIFO_DEPTH = 2;
  localparam int DEF_TAG_W      = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EN,
    S_WAIT,
    S_CAPT
  } state_e;

  // Job record layout at the default sizes; the top packs the same fields at its own widths.
  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } job_t;

endpackage

// File: rtl/add_serial_fifo.sv
// Small synchronous FIFO with async reset; head entry is visible on rd_data whenever non-empty.
module add_serial_fifo
  import add_serial_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/add_serial_seq.sv
// Operand sequencer / result collector wrapped around an external serial adder.
// Operands queue in a FIFO, are held on add_a/add_b for a whole add, and the sum is captured after ADD_LAT.
module add_serial_seq
  import add_serial_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADD_LAT    = DEF_ADD_LAT,
  parameter int EN_CYCLES  = DEF_EN_CYCLES,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TAG_W      = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             add_en,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy
);

  localparam int CNT_W  = $clog2(ADD_LAT + 1);
  localparam int JOB_W  = TAG_W + 2 * WIDTH;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] EN_LAST   = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ADD_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  add_a_q, add_a_d;
  logic [WIDTH-1:0]  add_b_q, add_b_d;
  logic [TAG_W-1:0]  job_tag_q, job_tag_d;
  logic [TAG_W-1:0]  in_tag_q, in_tag_d;
  logic              res_valid_q, res_valid_d;
  logic [WIDTH-1:0]  res_sum_q, res_sum_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;

  logic              fifo_full, fifo_empty;
  logic [FCNT_W-1:0] fifo_count;
  logic [JOB_W-1:0]  fifo_wr, fifo_rd;
  logic              push, pop, reload;

  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;
  assign fifo_wr  = {in_tag_q, in_a, in_b};

  add_serial_fifo #(
    .DATA_W (JOB_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (fifo_wr),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    job_tag_d   = job_tag_q;
    res_sum_d   = res_sum_q;
    res_tag_d   = res_tag_q;
    res_valid_d = res_valid_q;
    in_tag_d    = push ? in_tag_q + TAG_W'(1) : in_tag_q;
    pop         = 1'b0;
    reload      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop                              = 1'b1;
          {job_tag_d, add_a_d, add_b_d}    = fifo_rd;
          cnt_d                            = '0;
          state_d                          = S_EN;
        end
      end
      S_EN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == EN_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == WAIT_LAST) state_d = S_CAPT;
      end
      S_CAPT: begin
        // Stall here with operands held until the result register can take the sum.
        if (!res_valid_q || res_ready) begin
          reload    = 1'b1;
          res_sum_d = add_out;
          res_tag_d = job_tag_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (reload) begin
      res_valid_d = 1'b1;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      job_tag_q   <= '0;
      in_tag_q    <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      job_tag_q   <= job_tag_d;
      in_tag_q    <= in_tag_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_tag_q   <= res_tag_d;
    end
  end

  assign add_en    = (state_q == S_EN);
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_tag   = res_tag_q;
  assign busy      = (state_q != S_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_add_serial_seq.sv
// Bench for add_serial_seq: table of single jobs, directed multi-cycle corners, and a randomized
// phase checked by a queue-based scoreboard plus a latency-accurate adder model.
module tb_add_serial_seq;

  localparam int WIDTH      = 8;
  localparam int ADD_LAT    = 10;
  localparam int EN_CYCLES  = 2;
  localparam int FIFO_DEPTH = 2;
  localparam int TAG_W      = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic             add_en;
  logic [WIDTH-1:0] add_a, add_b, add_out;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic [TAG_W-1:0] res_tag;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add_serial_seq #(
    .WIDTH      (WIDTH),
    .ADD_LAT    (ADD_LAT),
    .EN_CYCLES  (EN_CYCLES),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TAG_W      (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_en    (add_en),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_out   (add_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_tag   (res_tag),
    .busy      (busy)
  );

  // Adder model: the sum only becomes correct ADD_LAT cycles after the start strobe rises;
  // before that it shows the complement, so an early capture is visible.
  logic [WIDTH-1:0] mdl_sum;
  int               mdl_age;
  logic             en_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_sum <= '0;
      mdl_age <= 0;
      en_d    <= 1'b0;
    end else begin
      en_d <= add_en;
      if (add_en && !en_d) begin
        mdl_sum <= add_a + add_b;
        mdl_age <= 1;
      end else if (mdl_age > 0 && mdl_age < 1000) begin
        mdl_age <= mdl_age + 1;
      end
    end
  end

  assign add_out = (mdl_age >= ADD_LAT) ? mdl_sum : ~mdl_sum;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every accepted input yields {tag, a+b mod 2^WIDTH}, delivered in order.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] sum;
  } res_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  res_t             exp_q[$];
  op_t              op_q[$];
  logic [TAG_W-1:0] model_tag = '0;
  int               en_cnt    = 0;
  int               last_t0   = 0;

  initial begin : monitor
    int               en_len;
    int               hold_left;
    logic [WIDTH-1:0] held_a, held_b, prev_sum;
    logic [TAG_W-1:0] prev_tag;
    logic             prev_en, prev_rv, prev_rr;
    res_t             r;
    op_t              o;
    en_len = 0; hold_left = 0; held_a = '0; held_b = '0; prev_sum = '0; prev_tag = '0;
    prev_en = 1'b0; prev_rv = 1'b0; prev_rr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        op_q.delete();
        model_tag = '0;
        hold_left = 0;
        en_len    = 0;
        prev_en   = 1'b0;
        prev_rv   = 1'b0;
        prev_rr   = 1'b0;
      end else begin
        if (prev_rv && !prev_rr) begin
          check_output("res_hold_valid", 32'(res_valid), 32'(1));
          check_output("res_hold_sum", 32'(res_sum), 32'(prev_sum));
          check_output("res_hold_tag", 32'(res_tag), 32'(prev_tag));
        end
        if (in_valid && in_ready) begin
          r.tag = model_tag;
          r.sum = in_a + in_b;
          exp_q.push_back(r);
          o.a = in_a;
          o.b = in_b;
          op_q.push_back(o);
          model_tag = model_tag + TAG_W'(1);
        end
        if (add_en && !prev_en) begin
          en_cnt++;
          last_t0 = cyc;
          en_len  = 1;
          if (op_q.size() == 0) begin
            check_output("op_unexpected", 32'(1), 32'(0));
          end else begin
            o = op_q.pop_front();
            check_output("add_a_t0", 32'(add_a), 32'(o.a));
            check_output("add_b_t0", 32'(add_b), 32'(o.b));
          end
          held_a    = add_a;
          held_b    = add_b;
          hold_left = ADD_LAT;
        end else begin
          if (add_en) en_len++;
          if (prev_en && !add_en) check_output("en_len", 32'(en_len), 32'(EN_CYCLES));
          if (hold_left > 0) begin
            check_output("add_a_hold", 32'(add_a), 32'(held_a));
            check_output("add_b_hold", 32'(add_b), 32'(held_b));
            hold_left--;
          end
        end
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            check_output("res_unexpected", 32'(1), 32'(0));
          end else begin
            r = exp_q.pop_front();
            check_output("res_sum", 32'(res_sum), 32'(r.sum));
            check_output("res_tag", 32'(res_tag), 32'(r.tag));
          end
        end
        prev_en  = add_en;
        prev_rv  = res_valid;
        prev_rr  = res_ready;
        prev_sum = res_sum;
        prev_tag = res_tag;
      end
    end
  end

  task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int guard;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    guard    = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!in_ready && guard < 100);
    if (!in_ready) check_output("push_timeout", 32'(0), 32'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_en(input int target, output int t0);
    int guard;
    guard = 0;
    while (en_cnt < target && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (en_cnt < target) check_output("t0_timeout", 32'(en_cnt), 32'(target));
    t0 = last_t0;
  endtask

  task automatic run_job(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp_sum, input logic [TAG_W-1:0] exp_tag);
    int n0, t0, guard;
    n0 = en_cnt;
    apply_stimulus(a, b);
    wait_en(n0 + 1, t0);
    guard = 0;
    while (!res_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_output("latency", 32'(cyc - t0), 32'(ADD_LAT + 1));
    check_output("job_sum", 32'(res_sum), 32'(exp_sum));
    check_output("job_tag", 32'(res_tag), 32'(exp_tag));
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main
    int t_a, t_b, n0, guard;
    vecs[0] = '{8'h03, 8'h05, 8'h08};
    vecs[1] = '{8'hFF, 8'h01, 8'h00};
    vecs[2] = '{8'h80, 8'h80, 8'h00};
    vecs[3] = '{8'h7F, 8'h01, 8'h80};
    vecs[4] = '{8'hAA, 8'h55, 8'hFF};
    vecs[5] = '{8'h12, 8'h34, 8'h46};
    vecs[6] = '{8'hFE, 8'hFE, 8'hFC};
    vecs[7] = '{8'h00, 8'h00, 8'h00};
    vecs[8] = '{8'hC8, 8'h64, 8'h2C};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_add_en", 32'(add_en), 32'(0));
    check_output("rst_add_a", 32'(add_a), 32'(0));
    check_output("rst_add_b", 32'(add_b), 32'(0));
    check_output("rst_res_valid", 32'(res_valid), 32'(0));
    check_output("rst_res_sum", 32'(res_sum), 32'(0));
    check_output("rst_res_tag", 32'(res_tag), 32'(0));
    check_output("rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    check_output("in_ready_after_reset", 32'(in_ready), 32'(1));

    $display("[TB] table of single jobs (tags wrap after 7)");
    for (int i = 0; i < 9; i++) begin
      run_job(vecs[i].a, vecs[i].b, vecs[i].sum, TAG_W'(i));
    end

    $display("[TB] back-to-back jobs");
    do_reset();
    n0 = en_cnt;
    apply_stimulus(8'hFF, 8'h01);
    apply_stimulus(8'h80, 8'h80);
    wait_en(n0 + 1, t_a);
    wait_en(n0 + 2, t_b);
    check_output("b2b_spacing", 32'(t_b - t_a), 32'(ADD_LAT + 2));
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_output("b2b_drain", 32'(exp_q.size()), 32'(0));

    $display("[TB] backpressure fill and stall");
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    apply_stimulus(8'h11, 8'h22);
    apply_stimulus(8'h33, 8'h44);
    apply_stimulus(8'h55, 8'h66);
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_a = 8'h77; in_b = 8'h99;
    repeat (2) @(negedge clk);
    check_output("fifo_full_ready", 32'(in_ready), 32'(0));
    check_output("fifo_full_busy", 32'(busy), 32'(1));
    guard = 0;
    while (!in_ready && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check_output("reoffer_accept", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    check_output("stall_valid", 32'(res_valid), 32'(1));
    check_output("stall_full", 32'(in_ready), 32'(0));
    check_output("stall_sum", 32'(res_sum), 32'(8'h33));
    check_output("stall_queued", 32'(exp_q.size()), 32'(4));
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || busy || res_valid) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_output("fill_drain", 32'(exp_q.size()), 32'(0));

    $display("[TB] reset during a job");
    do_reset();
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    n0 = en_cnt;
    apply_stimulus(8'h40, 8'h02);
    apply_stimulus(8'h10, 8'h20);
    wait_en(n0 + 2, t_a);
    while (cyc < t_a + 5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("mid_rst_add_en", 32'(add_en), 32'(0));
    check_output("mid_rst_add_a", 32'(add_a), 32'(0));
    check_output("mid_rst_add_b", 32'(add_b), 32'(0));
    check_output("mid_rst_res_valid", 32'(res_valid), 32'(0));
    check_output("mid_rst_res_sum", 32'(res_sum), 32'(0));
    check_output("mid_rst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    res_ready = 1'b1;
    run_job(8'h21, 8'h13, 8'h34, 3'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 1) == 1);
      in_a      = WIDTH'($urandom);
      in_b      = WIDTH'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || busy || res_valid) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check_output("random_drain", 32'(exp_q.size()), 32'(0));
    check_output("final_busy", 32'(busy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
